mem_write_milestone_checker: RTL and testbench
==============================================

# mem_write_milestone_checker

Synthesisable self-checking monitor that sits beside the multicycle `cpu` on its data-memory write bus (`memwrite`, `dataaddr`, `writedata`) and on `pc`. It replaces the single hard-coded "`dataaddr == 1` means success" probe with a programmable, ordered table of up to DEPTH expected writes. It also adds a cycle budget and a pc-hang detector, and reports pass/fail with a cause code and the offending write. Benches and FPGA bring-up builds instantiate it once per CPU.

## Interface
- WIDTH, 32, data/address/pc width
- DEPTH, 8, max expected writes in table (≥1)
- CYCLE_LIMIT, 1024, RUN cycles allowed before timeout (≥2)
- STALL_LIMIT, 16, consecutive RUN cycles with unchanged pc and no write that count as a hang (must exceed the CPU's longest instruction, 5)
- CNT_W, 16, width of cycle counter (2^CNT_W > CYCLE_LIMIT)

Ports (IW = $clog2(DEPTH), MW = $clog2(DEPTH+1)):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- prog_en  in  1  write table entry (honoured in IDLE/PASS/FAIL only)
- prog_idx  in  IW  entry index
- prog_addr  in  WIDTH  expected dataaddr
- prog_data  in  WIDTH  expected writedata
- exp_count  in  MW  number of entries to check; sampled on start
- start  in  1  begin a run (honoured outside RUN)
- memwrite  in  1  CPU store strobe
- dataaddr  in  WIDTH  CPU store address
- writedata  in  WIDTH  CPU store data
- pc  in  WIDTH  CPU program counter
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- fail_code  out  2  0 none, 1 mismatch, 2 timeout, 3 hang
- matched  out  MW  entries matched so far
- cycles  out  CNT_W  RUN cycles elapsed
- err_addr, err_data  out  WIDTH  dataaddr/writedata of the mismatching store (0 otherwise)

## Operation
- States: IDLE → RUN on start; RUN → PASS or FAIL; PASS/FAIL → RUN on start. Reset → IDLE from any state.
- Table: DEPTH flop pairs {addr, data}, cleared to 0 on reset, preserved across runs. prog_en in RUN is ignored.
- On start:
  - latch exp_count, saturated to DEPTH.
  - clear matched, cycles, the stall counter, fail_code, err_*.
  - capture pc as the stall reference.
- In RUN, each edge:
  - cycles increments.
  - If memwrite = 1, compare {dataaddr, writedata} to table[matched]:
    - equal → matched+1.
    - unequal → FAIL, code 1, latch err_addr/err_data.
  - Stall counter: resets when pc differs from the last pc or when memwrite = 1, otherwise increments. Reaching STALL_LIMIT → FAIL, code 3.
  - Cycle budget: cycles reaching CYCLE_LIMIT without completion → FAIL, code 2.
  - matched reaching the latched count → PASS.
- exp_count = 0: PASS on the first RUN edge.
- Priority on the same edge: completion (PASS) > mismatch > hang > timeout. A final matching store on the timeout edge therefore passes.
- Stores after PASS/FAIL are ignored. All outputs hold until the next start or reset.

## Timing
- All outputs are registered. Reset values: busy/done/pass 0, fail_code 0, matched 0, cycles 0, err_* 0.
- start sampled at edge N: busy = 1 after edge N, and cycles = 1 after edge N+1.
- Store sampled at edge K: matched/done/pass/fail_code update after edge K. The result is visible 1 cycle after the strobe edge.
- A start issued while in RUN is ignored. Reset asserted mid-RUN returns all outputs to reset values immediately (asynchronously). The table is also cleared.
- cycles never wraps: it stops counting once out of RUN.

## Test plan
- Single milestone: table[0] = {addr 1, data 1}, exp_count = 1, drive a store {1, 1} at RUN cycle 7 → pass = 1, matched = 1, cycles = 7, fail_code = 0.
- Ordered sequence: exp_count = 3, table {0x10/0xA, 0x14/0xB, 0x18/0xC}. Drive those stores in order with pc advancing → PASS. Swapping the 2nd and 3rd stores → FAIL code 1, err_addr = 0x18, err_data = 0xC, matched = 1.
- Timeout: CYCLE_LIMIT = 20, pc toggling, no stores → done after cycle 20, fail_code = 2, cycles = 20. Final matching store on cycle 20 → PASS instead.
- Hang: pc held at 0x40 with no stores for 16 cycles → FAIL code 3. pc held for 5 cycles per instruction → no hang.
- Reset mid-RUN after 2 of 3 matches → all outputs 0 and the table reads back 0. Re-program, then start → clean PASS.
- exp_count = 0 → PASS one edge after start. prog_en during RUN → table unchanged (verified by a later run).

Source files
------------

// File: rtl/mem_write_milestone_checker.sv
// Ordered store-sequence checker for the multicycle CPU data bus, with cycle budget and pc-hang detection.
// Outputs are registered; a store sampled at edge K is reflected in matched/done/pass/fail_code after edge K.
module mem_write_milestone_checker #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int CYCLE_LIMIT = 1024,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_W       = 16,
  parameter int IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int MW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_en,
  input  logic [IW-1:0]    prog_idx,
  input  logic [WIDTH-1:0] prog_addr,
  input  logic [WIDTH-1:0] prog_data,
  input  logic [MW-1:0]    exp_count,
  input  logic             start,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataaddr,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] pc,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [MW-1:0]    matched,
  output logic [CNT_W-1:0] cycles,
  output logic [WIDTH-1:0] err_addr,
  output logic [WIDTH-1:0] err_data
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] tab_addr [DEPTH];
  logic [WIDTH-1:0] tab_data [DEPTH];
  logic [MW-1:0]    exp_lat;
  logic [SW-1:0]    stall, stall_nx;
  logic [WIDTH-1:0] last_pc;
  logic [MW-1:0]    matched_nx;
  logic [CNT_W-1:0] cycles_nx;
  logic [1:0]       fail_nx;
  logic             mism;
  logic [MW-1:0]    exp_sat;
  logic [IW-1:0]    cmp_idx;

  assign exp_sat = (exp_count > MW'(DEPTH)) ? MW'(DEPTH) : exp_count;
  assign cmp_idx = matched[IW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    fail_nx    = 2'd0;
    mism       = 1'b0;
    matched_nx = matched;
    cycles_nx  = cycles + CNT_W'(1);
    // Stores beyond the expected count are neither matched nor flagged.
    if (memwrite && (matched < exp_lat)) begin
      if (dataaddr == tab_addr[cmp_idx] && writedata == tab_data[cmp_idx])
        matched_nx = matched + MW'(1);
      else
        mism = 1'b1;
    end
    stall_nx = (memwrite || pc != last_pc) ? '0 : stall + SW'(1);
    case (state)
      S_RUN: begin
        if (matched_nx == exp_lat) begin
          state_nx = S_PASS;
        end else if (mism) begin
          state_nx = S_FAIL;
          fail_nx  = 2'd1;
        end else if (stall_nx >= SW'(STALL_LIMIT)) begin
          state_nx = S_FAIL;
          fail_nx  = 2'd3;
        end else if (cycles_nx >= CNT_W'(CYCLE_LIMIT)) begin
          state_nx = S_FAIL;
          fail_nx  = 2'd2;
        end
      end
      default: if (start) state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tab_addr[i] <= '0;
        tab_data[i] <= '0;
      end
      exp_lat   <= '0;
      matched   <= '0;
      cycles    <= '0;
      stall     <= '0;
      last_pc   <= '0;
      fail_code <= 2'd0;
      err_addr  <= '0;
      err_data  <= '0;
    end else if (state != S_RUN) begin
      if (prog_en && int'(prog_idx) < DEPTH) begin
        tab_addr[prog_idx] <= prog_addr;
        tab_data[prog_idx] <= prog_data;
      end
      if (start) begin
        exp_lat   <= exp_sat;
        matched   <= '0;
        cycles    <= '0;
        stall     <= '0;
        last_pc   <= pc;
        fail_code <= 2'd0;
        err_addr  <= '0;
        err_data  <= '0;
      end
    end else begin
      matched   <= matched_nx;
      cycles    <= cycles_nx;
      stall     <= stall_nx;
      last_pc   <= pc;
      fail_code <= fail_nx;
      if (fail_nx == 2'd1) begin
        err_addr <= dataaddr;
        err_data <= writedata;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_PASS) || (state == S_FAIL);
  assign pass = (state == S_PASS);

endmodule

// File: tb/tb_mem_write_milestone_checker.sv
// Bench for mem_write_milestone_checker: directed scenarios plus a randomized run against a behavioural model.
module tb_mem_write_milestone_checker;
  localparam int WIDTH = 32, DEPTH = 8, CL = 20, SL = 16, CNT_W = 16, IW = 3, MW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic prog_en = 1'b0, start = 1'b0, memwrite = 1'b0;
  logic [IW-1:0] prog_idx = '0;
  logic [WIDTH-1:0] prog_addr = '0, prog_data = '0, dataaddr = '0, writedata = '0, pc = '0;
  logic [MW-1:0] exp_count = '0;
  logic busy, done, pass;
  logic [1:0] fail_code;
  logic [MW-1:0] matched;
  logic [CNT_W-1:0] cycles;
  logic [WIDTH-1:0] err_addr, err_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model: 0 idle, 1 run, 2 pass, 3 fail
  int m_state, m_exp, m_matched, m_cycles, m_stall, m_code;
  logic [31:0] m_ta [DEPTH];
  logic [31:0] m_td [DEPTH];
  logic [31:0] m_lastpc, m_eaddr, m_edata;

  mem_write_milestone_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CYCLE_LIMIT(CL), .STALL_LIMIT(SL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .prog_en(prog_en), .prog_idx(prog_idx), .prog_addr(prog_addr),
    .prog_data(prog_data), .exp_count(exp_count), .start(start), .memwrite(memwrite),
    .dataaddr(dataaddr), .writedata(writedata), .pc(pc), .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .matched(matched), .cycles(cycles), .err_addr(err_addr), .err_data(err_data)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_state = 0; m_exp = 0; m_matched = 0; m_cycles = 0; m_stall = 0; m_code = 0;
    m_lastpc = 0; m_eaddr = 0; m_edata = 0;
    for (int i = 0; i < DEPTH; i++) begin m_ta[i] = 0; m_td[i] = 0; end
  endfunction

  function automatic void model_edge();
    bit bad;
    bad = 0;
    if (m_state != 1) begin
      if (prog_en) begin m_ta[prog_idx] = prog_addr; m_td[prog_idx] = prog_data; end
      if (start) begin
        m_state = 1; m_exp = (int'(exp_count) > DEPTH) ? DEPTH : int'(exp_count);
        m_matched = 0; m_cycles = 0; m_stall = 0; m_code = 0; m_eaddr = 0; m_edata = 0;
        m_lastpc = pc;
      end
    end else begin
      m_cycles++;
      if (memwrite && m_matched < m_exp) begin
        if (dataaddr == m_ta[m_matched] && writedata == m_td[m_matched]) m_matched++;
        else bad = 1;
      end
      if (memwrite || pc != m_lastpc) m_stall = 0; else m_stall++;
      m_lastpc = pc;
      if (m_matched == m_exp) m_state = 2;
      else if (bad) begin m_state = 3; m_code = 1; m_eaddr = dataaddr; m_edata = writedata; end
      else if (m_stall >= SL) begin m_state = 3; m_code = 3; end
      else if (m_cycles >= CL) begin m_state = 3; m_code = 2; end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    memwrite = mw; dataaddr = a; writedata = d; pc = p;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic prog(input int idx, input logic [31:0] a, input logic [31:0] d);
    prog_en = 1'b1; prog_idx = IW'(idx); prog_addr = a; prog_data = d;
    tick();
    prog_en = 1'b0;
  endtask

  task automatic start_run(input int e);
    exp_count = MW'(e); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; model_reset();
    #11;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL reset_done_pass got %b%b want 00", done, pass); end
    checks++; if (fail_code !== 2'd0) begin errors++; $display("FAIL reset_code got %0d want 0", fail_code); end
    checks++; if (matched !== '0 || cycles !== '0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", matched, cycles); end
    checks++; if (err_addr !== '0 || err_data !== '0) begin errors++; $display("FAIL reset_err got %h/%h want 0/0", err_addr, err_data); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    prog(0, 32'd1, 32'd1);
    pc = 32'h0;
    start_run(1);
    checks++; if (busy !== 1'b1 || cycles !== '0) begin errors++; $display("FAIL single_start got busy %b cycles %0d want 1/0", busy, cycles); end
    for (int i = 1; i <= 6; i++) drive(1'b0, 0, 0, 32'(4 * i));
    checks++; if (done !== 1'b0 || cycles !== 16'd6) begin errors++; $display("FAIL single_mid got done %b cycles %0d want 0/6", done, cycles); end
    drive(1'b1, 32'd1, 32'd1, 32'd28);
    checks++; if (pass !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_pass got pass %b done %b busy %b want 1/1/0", pass, done, busy); end
    checks++; if (matched !== 4'd1 || cycles !== 16'd7 || fail_code !== 2'd0) begin errors++; $display("FAIL single_vals got %0d/%0d/%0d want 1/7/0", matched, cycles, fail_code); end
    for (int i = 0; i < 3; i++) drive(1'b1, 32'd9, 32'd9, 32'd0);
    checks++; if (cycles !== 16'd7 || pass !== 1'b1 || fail_code !== 2'd0) begin errors++; $display("FAIL single_hold got cycles %0d pass %b code %0d want 7/1/0", cycles, pass, fail_code); end
  endtask

  task automatic test_ordered();
    prog(0, 32'h10, 32'hA); prog(1, 32'h14, 32'hB); prog(2, 32'h18, 32'hC);
    start_run(3);
    drive(1'b1, 32'h10, 32'hA, 32'h4); drive(1'b0, 0, 0, 32'h8);
    drive(1'b1, 32'h14, 32'hB, 32'hC);
    checks++; if (matched !== 4'd2 || done !== 1'b0) begin errors++; $display("FAIL ordered_mid got matched %0d done %b want 2/0", matched, done); end
    drive(1'b1, 32'h18, 32'hC, 32'h10);
    checks++; if (pass !== 1'b1 || matched !== 4'd3) begin errors++; $display("FAIL ordered_pass got pass %b matched %0d want 1/3", pass, matched); end
    start_run(3);
    drive(1'b1, 32'h10, 32'hA, 32'h4);
    drive(1'b1, 32'h18, 32'hC, 32'h8);
    checks++; if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 2'd1) begin errors++; $display("FAIL swap_code got done %b pass %b code %0d want 1/0/1", done, pass, fail_code); end
    checks++; if (err_addr !== 32'h18 || err_data !== 32'hC || matched !== 4'd1) begin errors++; $display("FAIL swap_err got %h/%h/%0d want 18/c/1", err_addr, err_data, matched); end
  endtask

  task automatic test_timeout();
    prog(0, 32'h10, 32'hA);
    pc = 32'h300;
    start_run(1);
    for (int i = 1; i <= 19; i++) drive(1'b0, 0, 0, (i % 2) ? 32'h200 : 32'h204);
    checks++; if (done !== 1'b0 || cycles !== 16'd19) begin errors++; $display("FAIL timeout_early got done %b cycles %0d want 0/19", done, cycles); end
    drive(1'b0, 0, 0, 32'h204);
    checks++; if (done !== 1'b1 || fail_code !== 2'd2 || cycles !== 16'd20) begin errors++; $display("FAIL timeout got done %b code %0d cycles %0d want 1/2/20", done, fail_code, cycles); end
    start_run(1);
    for (int i = 1; i <= 19; i++) drive(1'b0, 0, 0, (i % 2) ? 32'h200 : 32'h204);
    drive(1'b1, 32'h10, 32'hA, 32'h200);
    checks++; if (pass !== 1'b1 || fail_code !== 2'd0 || cycles !== 16'd20) begin errors++; $display("FAIL timeout_edge_pass got pass %b code %0d cycles %0d want 1/0/20", pass, fail_code, cycles); end
  endtask

  task automatic test_hang();
    prog(0, 32'h20, 32'h21);
    pc = 32'h40;
    start_run(1);
    for (int i = 1; i <= 15; i++) drive(1'b0, 0, 0, 32'h40);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hang_early got done %b want 0", done); end
    drive(1'b0, 0, 0, 32'h40);
    checks++; if (fail_code !== 2'd3 || done !== 1'b1 || cycles !== 16'd16) begin errors++; $display("FAIL hang got code %0d done %b cycles %0d want 3/1/16", fail_code, done, cycles); end
    pc = 32'h100;
    start_run(1);
    for (int i = 1; i <= 17; i++) drive(1'b0, 0, 0, 32'h100 + 32'(4 * ((i - 1) / 5)));
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL nohang_mid got done %b code %0d want 0", done, fail_code); end
    drive(1'b1, 32'h20, 32'h21, 32'h10C);
    checks++; if (pass !== 1'b1 || fail_code !== 2'd0) begin errors++; $display("FAIL nohang_pass got pass %b code %0d want 1/0", pass, fail_code); end
  endtask

  task automatic test_back_to_back();
    prog(0, 32'h30, 32'h1); prog(1, 32'h34, 32'h2);
    start_run(2);
    drive(1'b1, 32'h30, 32'h1, 32'h4);
    exp_count = 4'd1; start = 1'b1;
    drive(1'b0, 0, 0, 32'h8);
    start = 1'b0;
    drive(1'b0, 0, 0, 32'hC);
    checks++; if (busy !== 1'b1 || matched !== 4'd1 || cycles !== 16'd3) begin errors++; $display("FAIL start_in_run got busy %b matched %0d cycles %0d want 1/1/3", busy, matched, cycles); end
    drive(1'b1, 32'h34, 32'h2, 32'h10);
    checks++; if (pass !== 1'b1 || matched !== 4'd2) begin errors++; $display("FAIL start_in_run_pass got pass %b matched %0d want 1/2", pass, matched); end
  endtask

  task automatic test_reset_midrun();
    prog(0, 32'h10, 32'hA); prog(1, 32'h14, 32'hB); prog(2, 32'h18, 32'hC);
    start_run(3);
    drive(1'b1, 32'h10, 32'hA, 32'h4); drive(1'b0, 0, 0, 32'h8); drive(1'b1, 32'h14, 32'hB, 32'hC);
    checks++; if (matched !== 4'd2 || busy !== 1'b1) begin errors++; $display("FAIL midrun_pre got matched %0d busy %b want 2/1", matched, busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || matched !== '0 || cycles !== '0) begin errors++; $display("FAIL midrun_reset got busy %b done %b matched %0d cycles %0d want 0", busy, done, matched, cycles); end
    #1 reset = 1'b0;
    model_reset();
    start_run(3);
    drive(1'b1, 0, 0, 32'h4); drive(1'b1, 0, 0, 32'h8); drive(1'b1, 0, 0, 32'hC);
    checks++; if (pass !== 1'b1 || matched !== 4'd3) begin errors++; $display("FAIL table_cleared got pass %b matched %0d want 1/3", pass, matched); end
    prog(0, 32'h10, 32'hA); prog(1, 32'h14, 32'hB); prog(2, 32'h18, 32'hC);
    start_run(3);
    drive(1'b1, 32'h10, 32'hA, 32'h4); drive(1'b1, 32'h14, 32'hB, 32'h8); drive(1'b1, 32'h18, 32'hC, 32'hC);
    checks++; if (pass !== 1'b1 || fail_code !== 2'd0 || err_addr !== '0) begin errors++; $display("FAIL reprog_pass got pass %b code %0d err %h want 1/0/0", pass, fail_code, err_addr); end
  endtask

  task automatic test_zero_and_prog_in_run();
    start_run(0);
    checks++; if (pass !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zero_start got pass %b busy %b want 0/1", pass, busy); end
    drive(1'b0, 0, 0, 32'h4);
    checks++; if (pass !== 1'b1 || cycles !== 16'd1 || matched !== '0) begin errors++; $display("FAIL zero_pass got pass %b cycles %0d matched %0d want 1/1/0", pass, cycles, matched); end
    prog(0, 32'h55, 32'h66);
    start_run(1);
    prog(0, 32'h77, 32'h88);
    drive(1'b1, 32'h55, 32'h66, 32'h8);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL prog_in_run got pass %b code %0d want 1/0", pass, fail_code); end
    start_run(1);
    drive(1'b1, 32'h55, 32'h66, 32'hC);
    checks++; if (pass !== 1'b1 || fail_code !== 2'd0) begin errors++; $display("FAIL prog_in_run_later got pass %b code %0d want 1/0", pass, fail_code); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      prog_en = ($urandom_range(0, 5) == 0);
      prog_idx = IW'($urandom_range(0, 7));
      prog_addr = $urandom_range(0, 3); prog_data = $urandom_range(0, 3);
      start = ($urandom_range(0, 9) == 0);
      exp_count = MW'($urandom_range(0, 15));
      memwrite = ($urandom_range(0, 2) == 0);
      if (memwrite && $urandom_range(0, 1) == 1 && m_matched < m_exp) begin
        dataaddr = m_ta[m_matched]; writedata = m_td[m_matched];
      end else begin
        dataaddr = $urandom_range(0, 3); writedata = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 3) == 0) pc = 32'($urandom_range(0, 3) * 4);
      tick();
      checks++; if (busy !== (m_state == 1)) begin errors++; $display("FAIL rnd_busy c%0d got %b want %b", c, busy, m_state == 1); end
      checks++; if (done !== (m_state >= 2) || pass !== (m_state == 2)) begin errors++; $display("FAIL rnd_done c%0d got %b%b want %b%b", c, done, pass, m_state >= 2, m_state == 2); end
      checks++; if (fail_code !== 2'(m_code)) begin errors++; $display("FAIL rnd_code c%0d got %0d want %0d", c, fail_code, m_code); end
      checks++; if (matched !== MW'(m_matched) || cycles !== CNT_W'(m_cycles)) begin errors++; $display("FAIL rnd_counts c%0d got %0d/%0d want %0d/%0d", c, matched, cycles, m_matched, m_cycles); end
      checks++; if (err_addr !== m_eaddr || err_data !== m_edata) begin errors++; $display("FAIL rnd_err c%0d got %h/%h want %h/%h", c, err_addr, err_data, m_eaddr, m_edata); end
    end
    prog_en = 1'b0; start = 1'b0; memwrite = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_single();
    test_ordered();
    test_timeout();
    test_hang();
    test_back_to_back();
    test_reset_midrun();
    test_zero_and_prog_in_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
